// File: rtl/mem_bus_arb_pkg.sv
// Shared state encoding and parameter limits for the memory bus arbiter.
// The optional lock feature is selected with the MEM_BUS_ARB_LOCK_EN macro.
package mem_bus_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int MAX_CH     = 8;
    localparam int MAX_RD_LAT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } state_e;

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Combinational request picker: round-robin starting after rr_ptr_i, or
// fixed priority with channel 0 highest. Produces one-hot and encoded grant.
module arb_pick #(
    parameter int NUM_CH    = 4,
    parameter int IW        = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     rr_ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     gnt_idx_o,
    output logic              any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (FIXED_PRI != 0) begin
                idx = IW'(k);
            end else begin
                // One subtraction suffices: rr_ptr_i + 1 + k never reaches 2*NUM_CH.
                sum = {1'b0, rr_ptr_i} + (IW+1)'(k + 1);
                if (sum >= (IW+1)'(NUM_CH)) begin
                    sum = sum - (IW+1)'(NUM_CH);
                end
                idx = sum[IW-1:0];
            end
            if (!any_o && req_i[idx]) begin
                any_o     = 1'b1;
                gnt_idx_o = idx;
            end
        end
        gnt_o[gnt_idx_o] = any_o;
    end

endmodule

// File: rtl/mem_bus_arb.sv
// N-master arbiter serialising request/ack transactions onto one memory port.
// Define MEM_BUS_ARB_LOCK_EN to add the m_lock debugger hold port.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  m_req,
`ifdef MEM_BUS_ARB_LOCK_EN
    input  logic [NUM_CH-1:0]  m_lock,
`endif
    input  logic [NUM_CH-1:0]  m_r_nw,
    input  logic [NUM_CH*AW-1:0] m_a,
    input  logic [NUM_CH*DW-1:0] m_wdata,
    output logic [NUM_CH-1:0]  m_ack,
    output logic [NUM_CH-1:0]  m_rvalid,
    output logic [DW-1:0]      m_rdata,
    output logic [AW-1:0]      mem_a,
    output logic               mem_wr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int IW = $clog2(NUM_CH);
    localparam int LW = $clog2(RD_LAT + 1);

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("mem_bus_arb: NUM_CH must be in 2..%0d", MAX_CH);
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $error("mem_bus_arb: RD_LAT must be in 1..%0d", MAX_RD_LAT);
    end

    state_e              state_q;
    logic [IW-1:0]       g_q;
    logic [IW-1:0]       rr_ptr_q;
    logic                r_nw_q;
    logic [LW-1:0]       lat_q;
    logic [AW-1:0]       mem_a_q;
    logic [DW-1:0]       mem_din_q;
    logic                mem_wr_q;
    logic [NUM_CH-1:0]   ack_q;
    logic [NUM_CH-1:0]   rvalid_q;
    logic [DW-1:0]       rdata_q;

    logic [NUM_CH-1:0]   elig_req;
    logic [NUM_CH-1:0]   gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic [NUM_CH-1:0]   g_oh;
    logic [AW-1:0]       sel_a;
    logic [DW-1:0]       sel_wd;
    logic                sel_rnw;
    logic                lock_active;

    always_comb begin
        sel_a   = '0;
        sel_wd  = '0;
        sel_rnw = 1'b0;
        g_oh    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == IW'(k)) begin
                sel_a   = m_a[k*AW +: AW];
                sel_wd  = m_wdata[k*DW +: DW];
                sel_rnw = m_r_nw[k];
            end
            g_oh[k] = (g_q == IW'(k));
        end
    end

`ifdef MEM_BUS_ARB_LOCK_EN
    logic lock_hold_q;
    logic lock_g;
    assign lock_g      = |(m_lock & g_oh);
    assign lock_active = lock_hold_q & lock_g;
`else
    assign lock_active = 1'b0;
`endif

    // While the last owner holds its lock only that owner may be granted.
    assign elig_req = lock_active ? (m_req & g_oh) : m_req;

    arb_pick #(
        .NUM_CH    (NUM_CH),
        .IW        (IW),
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req_i     (elig_req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            rr_ptr_q  <= IW'(NUM_CH - 1);
            r_nw_q    <= 1'b0;
            lat_q     <= '0;
            mem_a_q   <= '0;
            mem_din_q <= '0;
            mem_wr_q  <= 1'b0;
            ack_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
`ifdef MEM_BUS_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            ack_q    <= '0;
            rvalid_q <= '0;
            mem_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef MEM_BUS_ARB_LOCK_EN
                    if (lock_hold_q && !lock_g) begin
                        lock_hold_q <= 1'b0;
                    end
`endif
                    if (gnt_any) begin
                        g_q       <= gnt_idx;
                        r_nw_q    <= sel_rnw;
                        mem_a_q   <= sel_a;
                        mem_din_q <= sel_wd;
                        ack_q     <= gnt;
                        mem_wr_q  <= ~sel_rnw;
                        state_q   <= S_ISSUE;
                        if (!lock_active) begin
                            rr_ptr_q <= gnt_idx;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_nw_q) begin
                        lat_q   <= LW'(RD_LAT - 1);
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
`ifdef MEM_BUS_ARB_LOCK_EN
                        lock_hold_q <= lock_g;
`endif
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        rdata_q  <= mem_dout;
                        rvalid_q <= g_oh;
                        state_q  <= S_IDLE;
`ifdef MEM_BUS_ARB_LOCK_EN
                        lock_hold_q <= lock_g;
`endif
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_ack     = ack_q;
    assign m_rvalid  = rvalid_q;
    assign m_rdata   = rdata_q;
    assign mem_a     = mem_a_q;
    assign mem_wr    = mem_wr_q;
    assign mem_din   = mem_din_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: a round-robin and a fixed-priority instance (RD_LAT=2),
// each with its own latency-pipelined memory model and ack/read scoreboards.
module tb_mem_bus_arb;
  import mem_bus_arb_pkg::*;

  localparam int NCH = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] req_rr, req_fp;
  logic [NCH-1:0] rnw;
  logic [NCH*AW-1:0] ma;
  logic [NCH*DW-1:0] wd;
`ifdef MEM_BUS_ARB_LOCK_EN
  logic [NCH-1:0] lock_rr;
`endif

  logic [NCH-1:0] ack_rr, rvalid_rr, ack_fp, rvalid_fp;
  logic [DW-1:0] rdata_rr, rdata_fp, memdin_rr, memdin_fp, dout_rr, dout_fp;
  logic [AW-1:0] mema_rr, mema_fp;
  logic memwr_rr, memwr_fp, busy_rr, busy_fp;
  logic [1:0] dbg_rr, dbg_fp;

  int n_cmp = 0;
  int n_err = 0;

  logic [NCH-1:0] exp_ack_rr_q[$];
  logic [NCH-1:0] exp_ack_fp_q[$];
  logic [NCH+DW-1:0] exp_rd_rr_q[$];
  logic [NCH+DW-1:0] exp_rd_fp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  mem_bus_arb #(.NUM_CH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIXED_PRI(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .m_req(req_rr),
`ifdef MEM_BUS_ARB_LOCK_EN
    .m_lock(lock_rr),
`endif
    .m_r_nw(rnw), .m_a(ma), .m_wdata(wd),
    .m_ack(ack_rr), .m_rvalid(rvalid_rr), .m_rdata(rdata_rr),
    .mem_a(mema_rr), .mem_wr(memwr_rr), .mem_din(memdin_rr), .mem_dout(dout_rr),
    .busy(busy_rr), .dbg_state(dbg_rr)
  );

  mem_bus_arb #(.NUM_CH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_req(req_fp),
`ifdef MEM_BUS_ARB_LOCK_EN
    .m_lock('0),
`endif
    .m_r_nw(rnw), .m_a(ma), .m_wdata(wd),
    .m_ack(ack_fp), .m_rvalid(rvalid_fp), .m_rdata(rdata_fp),
    .mem_a(mema_fp), .mem_wr(memwr_fp), .mem_din(memdin_fp), .mem_dout(dout_fp),
    .busy(busy_fp), .dbg_state(dbg_fp)
  );

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h2C;
  endfunction

  logic [DW-1:0] pipe_rr [RD_LAT];
  logic [DW-1:0] pipe_fp [RD_LAT];

  always @(posedge clk) begin
    pipe_rr[0] <= mem_fn(mema_rr);
    pipe_fp[0] <= mem_fn(mema_fp);
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_rr[k] <= pipe_rr[k-1];
      pipe_fp[k] <= pipe_fp[k-1];
    end
  end
  assign dout_rr = pipe_rr[RD_LAT-1];
  assign dout_fp = pipe_fp[RD_LAT-1];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every ack / rvalid strobe pops the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_rr != '0) begin
        if (exp_ack_rr_q.size() == 0) check("rr_ack_unexpected", 64'(ack_rr), 64'd0);
        else check("rr_ack_order", 64'(ack_rr), 64'(exp_ack_rr_q.pop_front()));
      end
      if (rvalid_rr != '0) begin
        if (exp_rd_rr_q.size() == 0) check("rr_rvalid_unexpected", 64'(rvalid_rr), 64'd0);
        else check("rr_rd", 64'({rvalid_rr, rdata_rr}), 64'(exp_rd_rr_q.pop_front()));
      end
      if (ack_fp != '0) begin
        if (exp_ack_fp_q.size() == 0) check("fp_ack_unexpected", 64'(ack_fp), 64'd0);
        else check("fp_ack_order", 64'(ack_fp), 64'(exp_ack_fp_q.pop_front()));
      end
      if (rvalid_fp != '0) begin
        if (exp_rd_fp_q.size() == 0) check("fp_rvalid_unexpected", 64'(rvalid_fp), 64'd0);
        else check("fp_rd", 64'({rvalid_fp, rdata_fp}), 64'(exp_rd_fp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rnw[ch] = r;
    ma[ch*AW +: AW] = a;
    wd[ch*DW +: DW] = d;
  endtask

  task automatic wait_ack(input bit use_fp, input logic [NCH-1:0] exp, input string tag);
    bit got;
    logic [NCH-1:0] obs;
    got = 1'b0;
    obs = '0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      obs = use_fp ? ack_fp : ack_rr;
      if (obs != '0) got = 1'b1;
    end
    check({tag, "_seen"}, 64'(got), 64'd1);
    check(tag, 64'(obs), 64'(exp));
  endtask

  // ---------------- main sequence ----------------
  int busy_cnt, rv_cyc, n0, n1, n3, n_gnt, rv_cnt;
  logic [AW-1:0] a_k;

  initial begin
    rst_n = 1'b0;
    req_rr = '0;
    req_fp = '0;
    rnw = '1;
    ma = '0;
    wd = '0;
`ifdef MEM_BUS_ARB_LOCK_EN
    lock_rr = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_rr_outs", 64'({ack_rr, rvalid_rr, rdata_rr, mema_rr, memwr_rr, memdin_rr, busy_rr}), 64'd0);
    check("rst_fp_outs", 64'({ack_fp, rvalid_fp, rdata_fp, mema_fp, memwr_fp, memdin_fp, busy_fp}), 64'd0);
    check("rst_state", 64'(dbg_rr), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single write on ch2 (fixed priority instance).
    set_ch(2, 1'b0, 16'h0300, 8'hA5);
    req_fp = 4'b0100;
    exp_ack_fp_q.push_back(4'b0100);
    @(negedge clk);
    check("wr_ack", 64'(ack_fp), 64'h4);
    check("wr_en", 64'(memwr_fp), 64'd1);
    check("wr_addr", 64'(mema_fp), 64'h0300);
    check("wr_data", 64'(memdin_fp), 64'hA5);
    req_fp = '0;
    @(negedge clk);
    check("wr_en_one_cycle", 64'(memwr_fp), 64'd0);
    check("wr_addr_hold", 64'(mema_fp), 64'h0300);
    check("wr_busy_done", 64'(busy_fp), 64'd0);

    // Read on ch1; address changed after grant must be ignored.
    set_ch(1, 1'b1, 16'h0010, 8'h00);
    req_fp = 4'b0010;
    exp_ack_fp_q.push_back(4'b0010);
    exp_rd_fp_q.push_back({4'b0010, 8'h3C});
    busy_cnt = 0;
    rv_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_fp = '0;
        set_ch(1, 1'b1, 16'hFFFF, 8'h00);
      end
      if (busy_fp) busy_cnt++;
      if (rvalid_fp[1] && rv_cyc == 0) rv_cyc = c;
    end
    check("rd_rvalid_cycle", 64'(rv_cyc), 64'd4);
    check("rd_busy_cycles", 64'(busy_cnt), 64'd3);
    check("rd_rdata_hold", 64'(rdata_fp), 64'h3C);

    // Fixed priority: ch0 and ch3 continuous, ch3 starves until ch0 drops.
    set_ch(0, 1'b1, 16'h1234, 8'h00);
    set_ch(3, 1'b1, 16'h0BEE, 8'h00);
    req_fp = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      exp_ack_fp_q.push_back(4'b0001);
      exp_rd_fp_q.push_back({4'b0001, mem_fn(16'h1234)});
    end
    exp_ack_fp_q.push_back(4'b1000);
    exp_rd_fp_q.push_back({4'b1000, mem_fn(16'h0BEE)});
    n0 = 0;
    n3 = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack_fp[0]) n0++;
      if (ack_fp[3]) n3++;
    end
    req_fp = 4'b1000;
    check("fp_ch0_grants", 64'(n0), 64'd4);
    check("fp_ch3_starved", 64'(n3), 64'd0);
    wait_ack(1'b1, 4'b1000, "fp_ch3_after_release");
    req_fp = '0;
    repeat (6) @(negedge clk);

    // Round-robin from reset: all four channels read continuously.
    for (int k = 0; k < NCH; k++) begin
      a_k = 16'h4000 + 16'(k * 16'h0111);
      set_ch(k, 1'b1, a_k, 8'h00);
    end
    for (int i = 0; i < 5; i++) begin
      a_k = 16'h4000 + 16'((i % NCH) * 16'h0111);
      exp_ack_rr_q.push_back(4'(1 << (i % NCH)));
      exp_rd_rr_q.push_back({4'(1 << (i % NCH)), mem_fn(a_k)});
    end
    req_rr = 4'b1111;
    n_gnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack_rr != '0) begin
        n_gnt++;
        check("rr_ack_onehot", 64'($countones(ack_rr)), 64'd1);
      end
    end
    req_rr = '0;
    check("rr_grant_count", 64'(n_gnt), 64'd5);
    repeat (2) @(negedge clk);

    // Reset during WAIT discards the read and restores the ch0-first pointer.
    set_ch(2, 1'b1, 16'h2222, 8'h00);
    req_rr = 4'b0100;
    exp_ack_rr_q.push_back(4'b0100);
    @(negedge clk);
    req_rr = '0;
    @(negedge clk);
    check("mid_busy_before_rst", 64'(dbg_rr), 64'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 64'({ack_rr, rvalid_rr, rdata_rr, mema_rr, memwr_rr, memdin_rr, busy_rr}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid_rr != '0) rv_cnt++;
    end
    check("mid_no_rvalid", 64'(rv_cnt), 64'd0);
    set_ch(0, 1'b1, 16'h0A0A, 8'h00);
    set_ch(3, 1'b1, 16'h3003, 8'h00);
    exp_ack_rr_q.push_back(4'b0001);
    exp_rd_rr_q.push_back({4'b0001, mem_fn(16'h0A0A)});
    exp_ack_rr_q.push_back(4'b1000);
    exp_rd_rr_q.push_back({4'b1000, mem_fn(16'h3003)});
    req_rr = 4'b1001;
    wait_ack(1'b0, 4'b0001, "rst_ch0_first");
    req_rr = 4'b1000;
    wait_ack(1'b0, 4'b1000, "rst_ch3_next");
    req_rr = '0;
    repeat (6) @(negedge clk);

`ifdef MEM_BUS_ARB_LOCK_EN
    // ch1 holds its lock for three back-to-back writes while ch0 waits.
    set_ch(1, 1'b0, 16'h0501, 8'h11);
    set_ch(0, 1'b0, 16'h0500, 8'h22);
    for (int i = 0; i < 3; i++) exp_ack_rr_q.push_back(4'b0010);
    exp_ack_rr_q.push_back(4'b0001);
    lock_rr = 4'b0010;
    req_rr = 4'b0010;
    n0 = 0;
    n1 = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req_rr = 4'b0011;
      if (ack_rr[1]) n1++;
      if (ack_rr[0]) n0++;
      if (c == 5) req_rr = 4'b0001;
    end
    check("lock_ch1_grants", 64'(n1), 64'd3);
    check("lock_ch0_stalled", 64'(n0), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("lock_stall_ack", 64'(ack_rr), 64'd0);
    end
    lock_rr = '0;
    @(negedge clk);
    check("lock_release_ch0", 64'(ack_rr), 64'h1);
    req_rr = '0;
    repeat (3) @(negedge clk);
`endif

    check("rr_ack_q_empty", 64'(exp_ack_rr_q.size()), 64'd0);
    check("rr_rd_q_empty", 64'(exp_rd_rr_q.size()), 64'd0);
    check("fp_ack_q_empty", 64'(exp_ack_fp_q.size()), 64'd0);
    check("fp_rd_q_empty", 64'(exp_rd_fp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
